// File: rtl/side_request_unit.sv
// Side-road request front end: debounces a raw button and holds one request per press until serviced.
// Latency: button rises DEBOUNCE_CYCLES+1 edges after btn_raw settles high; other flags update on their triggering edge.
// Backpressure: the request is held until side_yellow is seen; presses arriving while a request is open are dropped.
module side_request_unit #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MAX_MISS        = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_raw,
  input  logic       i_main_green,
  input  logic       i_side_yellow,
  input  logic       i_side_green,
  output logic       o_button,
  output logic       o_req_pending,
  output logic       o_served_pulse,
  output logic [7:0] o_req_count,
  output logic       o_fault
);

  localparam logic [0:0] DB_UP   = 1'b0;
  localparam logic [0:0] DB_DOWN = 1'b1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PENDING = 2'd1;
  localparam logic [1:0] S_SERVING = 2'd2;
  localparam logic [1:0] S_GREEN   = 2'd3;

  // The D-th stable sample is the one presented while the counter holds D-1.
  localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] MISS_MAX  = 4'(MAX_MISS);
  localparam logic [3:0] MISS_LAST = 4'(MAX_MISS - 1);

  logic [1:0] r_sync;
  logic [0:0] r_db_state;
  logic [7:0] r_db_cnt;
  logic [1:0] r_state;
  logic [3:0] r_miss;
  logic [7:0] r_count;
  logic       r_fault;
  logic       r_served;

  logic       w_btn_s;
  logic       w_db_last;
  logic       w_press_evt;

  assign w_btn_s     = r_sync[1];
  assign w_db_last   = (r_db_cnt == DB_LAST);
  // Press is flagged while the final qualifying sample is presented; it lasts one cycle
  // because the same edge moves the debouncer into DOWN_WAIT.
  assign w_press_evt = (r_db_state == DB_UP) && w_btn_s && w_db_last;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_btn_raw};
    end
  end

  // Debounce: count consecutive stable samples toward press, then toward release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db_state <= DB_UP;
      r_db_cnt   <= 8'd0;
    end else if (r_db_state == DB_UP) begin
      if (!w_btn_s) begin
        r_db_cnt <= 8'd0;
      end else if (w_db_last) begin
        r_db_state <= DB_DOWN;
        r_db_cnt   <= 8'd0;
      end else begin
        r_db_cnt <= r_db_cnt + 8'd1;
      end
    end else begin
      if (w_btn_s) begin
        r_db_cnt <= 8'd0;
      end else if (w_db_last) begin
        r_db_state <= DB_UP;
        r_db_cnt   <= 8'd0;
      end else begin
        r_db_cnt <= r_db_cnt + 8'd1;
      end
    end
  end

  // Request tracking: latch, watch for ignored main-green cycles, follow side service.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_miss   <= 4'd0;
      r_count  <= 8'd0;
      r_fault  <= 1'b0;
      r_served <= 1'b0;
    end else begin
      r_served <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_press_evt) begin
            r_state <= S_PENDING;
            r_miss  <= 4'd0;
            if (r_count != 8'hFF) begin
              r_count <= r_count + 8'd1;
            end
          end
        end
        S_PENDING: begin
          // Service start takes priority over counting a miss in the same cycle.
          if (i_side_yellow) begin
            r_state <= S_SERVING;
          end else if (i_main_green && (r_miss != MISS_MAX)) begin
            r_miss <= r_miss + 4'd1;
            if (r_miss == MISS_LAST) begin
              r_fault <= 1'b1;
            end
          end
        end
        S_SERVING: begin
          if (i_side_green) begin
            r_state <= S_GREEN;
          end else if (!i_side_yellow) begin
            // Yellow vanished without green: service aborted, no completion pulse.
            r_state <= S_IDLE;
          end
        end
        S_GREEN: begin
          if (!i_side_green) begin
            r_state  <= S_IDLE;
            r_served <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_button       = (r_state == S_PENDING);
  assign o_req_pending  = (r_state != S_IDLE);
  assign o_served_pulse = r_served;
  assign o_req_count    = r_count;
  assign o_fault        = r_fault;

endmodule

// File: doc/side_request_unit.md
# side_request_unit

Pedestrian/side-road request front end that produces the `button` request consumed by the traffic light controller. It synchronizes and debounces a raw push-button and latches one request per press. It holds the request until the controller visibly starts side service, then tracks that service to completion. It also counts accepted presses and flags a sticky fault if a pending request is ignored during main-green phases.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples (1..255) required to accept a press or a release.
- `MAX_MISS`, default 2: main-green cycles observed while PENDING before `fault` sets (1..15).
- `clk` input 1: clock; all logic is rising-edge.
- `rst` input 1: reset, asynchronous, active-high.
- `btn_raw` input 1: asynchronous, bouncy push-button, active-high.
- `main_green` input 1: controller lamp output.
- `side_yellow` input 1: controller lamp output.
- `side_green` input 1: controller lamp output.
- `button` output 1: registered request level to the controller; high exactly while PENDING.
- `req_pending` output 1: high in PENDING, SERVING or GREEN.
- `served_pulse` output 1: one-cycle pulse when a side-green phase completes.
- `req_count` output 8: accepted presses, saturating at 255.
- `fault` output 1: sticky; a request was ignored for `MAX_MISS` main-green cycles.

## Operation
- Synchronizer: two flops on `btn_raw` produce `btn_s`. There is no other use of `btn_raw`.
- Debounce FSM:
  - UP_WAIT: counts consecutive `btn_s`=1 edges. Any 0 clears the count.
  - At count = `DEBOUNCE_CYCLES`, the FSM emits internal `press_evt` for one cycle and moves to DOWN_WAIT.
  - DOWN_WAIT: counts consecutive `btn_s`=0 edges. At `DEBOUNCE_CYCLES`, it returns to UP_WAIT.
  - A held button yields exactly one `press_evt`.
- Request FSM, states IDLE, PENDING, SERVING, GREEN:
  - IDLE: on `press_evt`, go to PENDING, increment `req_count` (saturating), and clear the miss counter.
  - PENDING: if `side_yellow`=1, go to SERVING. Otherwise, each cycle with `main_green`=1 increments the miss counter. When the counter reaches `MAX_MISS`, `fault` sets and the FSM stays in PENDING.
  - SERVING: if `side_green`=1, go to GREEN. Otherwise, if `side_yellow`=0, return to IDLE with no `served_pulse` (service aborted, e.g. controller reset).
  - GREEN: when `side_green`=0, go to IDLE and pulse `served_pulse`.
- A `press_evt` in PENDING, SERVING or GREEN is ignored. It does not increment `req_count` and is not queued.
- `side_yellow` arriving in IDLE (a request from another source) is ignored.
- `req_count` holds at 255. `fault` clears only on `rst`.

## Timing
- Reset values: `button`=0, `req_pending`=0, `served_pulse`=0, `req_count`=0, `fault`=0. Both FSMs are in IDLE/UP_WAIT with counters at 0 and synchronizer flops at 0.
- Press latency: with `btn_raw` rising before edge k and held stable, `btn_s`=1 after edge k+1, `press_evt` is high after edge k+`DEBOUNCE_CYCLES`, and `button`/`req_pending` rise after edge k+`DEBOUNCE_CYCLES`+1. With the default, `button` rises 5 edges after stable input.
- `button` falls on the edge that samples `side_yellow`=1, so it is low from the first full side-yellow cycle.
- `served_pulse` is high for exactly the cycle after the edge that samples `side_green`=0 in GREEN.
- `req_count` and `fault` update on the same edge as their triggering transition.
- Simultaneous `side_yellow`=1 and `main_green`=1 in PENDING: the SERVING transition wins and the miss is not counted.
- A bounce shorter than `DEBOUNCE_CYCLES` samples produces no event in either direction.
- `rst` asserted mid-operation forces all reset values immediately. Release resumes from IDLE/UP_WAIT. A button still held at release must be seen stable for `DEBOUNCE_CYCLES` before it is accepted.

## Test plan
- Clean press, `DEBOUNCE_CYCLES`=4: `btn_raw` held high for 20 cycles, stable before edge 10 → `button` rises after edge 15, `req_count`=1, and only one request is made despite the hold.
- Bounce: `btn_raw` toggles 1,0,1,1,0,1,1,1,0 at one cycle each, then stays 0 → no `press_evt`, `button` stays 0, `req_count`=0.
- Full service: press, then drive `main_green`=1 for 1 cycle, `side_yellow` for 1 cycle, `side_green` for 1 cycle, then all 0 → `button` falls on the edge sampling `side_yellow`. `served_pulse` is high for one cycle after `side_green` falls. State returns to IDLE and `req_pending`=0.
- Miss fault, `MAX_MISS`=2: press, then two separated `main_green` pulses with no `side_yellow` → `fault`=1 after the second pulse. `button` stays 1, `fault` stays 1 after later service, and clears only on `rst`.
- Abort and ignore: a press during GREEN is not counted (`req_count` unchanged). A second case drops `side_yellow` to 0 in SERVING without `side_green` → IDLE with no `served_pulse`.
- Saturation and reset: 256 valid presses each serviced → `req_count`=255. Then assert `rst` while in PENDING → all outputs 0 immediately.
